switch_output_arbiter: RTL and testbench
========================================

SWITCH_OUTPUT_ARBITER -- requirements
Module: switch_output_arbiter

Interface
REQ-001 Parameter NUMBERINPUTS, default 4, number of switch input ports competing for this output port.
REQ-002 Parameter LOGNUMBERINPUTS, default 2, width of the input index; SHALL equal ceil(log2(NUMBERINPUTS)).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_hdr  input  NUMBERINPUTS  bit i: input i presents a valid header flit (type 3'b011) whose target field equals this output port.
REQ-006 req_valid  input  NUMBERINPUTS  bit i: input i presents any valid flit.
REQ-007 req_tail  input  NUMBERINPUTS  bit i: flit at input i is a tail flit (type 3'b000).
REQ-008 out_stall  input  1  downstream stall/go stall; 1 blocks transfer this cycle.
REQ-009 grant  output  NUMBERINPUTS  one-hot grant to the owning input; all zero when unlocked.
REQ-010 grant_idx  output  LOGNUMBERINPUTS  binary index of the owning input (crossbar mux select).
REQ-011 locked  output  1  1 while a packet owns the output.
REQ-012 fire  output  1  1 when a flit transfers this cycle: locked & req_valid[grant_idx] & ~out_stall.
REQ-013 in_stall  output  NUMBERINPUTS  per-input stall back to the input buffers; 0 only for the owner when ~out_stall, 1 otherwise.

Function
REQ-014 Two states, IDLE and LOCKED; grant, grant_idx, locked are registered outputs; fire and in_stall are combinational from registered state and current inputs.
REQ-015 IDLE: when any req_hdr bit is set, the winner SHALL be the first set bit at or after priority pointer ptr (cyclic search upward, wrapping NUMBERINPUTS-1 -> 0); next cycle state=LOCKED, grant=one-hot(winner), grant_idx=winner.
REQ-016 Arbitration latency one cycle: the header is not transferred in the decision cycle; it transfers in the first LOCKED cycle with ~out_stall.
REQ-017 On the arbitration decision, ptr <= winner+1 modulo NUMBERINPUTS (wrap: NUMBERINPUTS-1 -> 0).
REQ-018 IDLE with req_hdr==0: state, ptr, outputs unchanged.
REQ-019 LOCKED: grant holds regardless of req_hdr from other inputs; req_valid/req_tail of non-owners are ignored.
REQ-020 LOCKED with fire & req_tail[grant_idx]: next state IDLE, grant cleared, locked=0; new arbitration can occur only in the following IDLE cycle (one bubble cycle minimum between packets).
REQ-021 LOCKED with req_tail[grant_idx] and out_stall=1: no fire, remain LOCKED.
REQ-022 LOCKED with req_valid[grant_idx]=0: no fire, remain LOCKED (owner bubble tolerated, no timeout).
REQ-023 If req_hdr[grant_idx] asserts while LOCKED it is transferred as an ordinary flit; no re-arbitration.
REQ-024 In IDLE, fire=0 and in_stall all ones.

Reset
REQ-025 rst=1 on a rising edge: state=IDLE, ptr=0, grant=0, grant_idx=0, locked=0; any packet in progress is abandoned without a tail.
REQ-026 While rst=1, fire=0 and in_stall all ones.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE, LOCKED) and flit type codes (HEADER 3'b011, PAYLOAD 3'b010, TAIL 3'b000), shared with the switch and the traffic generators.
REQ-028 Round-robin search SHALL be a sub-module rr_priority_picker (inputs req vector and ptr; outputs found, winner index) and SHALL be reused by the other output ports.

Verification
REQ-029 After reset, req_hdr=4'b0110 -> next cycle grant=4'b0010, grant_idx=1, ptr=2.
REQ-030 Owner 1 sends header, 2 payloads, tail with out_stall=0 -> fire in 4 consecutive cycles, locked drops the cycle after the tail; req_hdr[2] held throughout -> grant=4'b0100 one cycle later.
REQ-031 ptr=3, req_hdr=4'b1001 -> winner 3, ptr wraps to 0; next arbitration with 4'b1001 -> winner 0.
REQ-032 LOCKED owner 0, out_stall=1 for 3 cycles with tail present -> fire=0, in_stall=4'b1111, remain LOCKED; out_stall=0 -> fire=1, then IDLE.
REQ-033 rst asserted mid-packet (LOCKED, ptr=2) -> next cycle grant=0, locked=0, ptr=0; req_hdr=4'b1111 -> grant=4'b0001.
REQ-034 All four inputs hold headers continuously -> grants rotate 0,1,2,3,0 over successive packets with no input granted twice before the others.

Source files
------------

// File: rtl/switch_output_arbiter_pkg.sv
// Shared definitions for the switch output arbiters, the switch and the traffic generators.
// Holds the arbiter state encoding and the flit type codes carried on the flit type field.
// Latency: none (types and constants only). Backpressure: not applicable.
package switch_output_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic [2:0] FLIT_HEADER  = 3'b011;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b000;

  function automatic logic is_header(input logic [2:0] flit_type);
    return flit_type == FLIT_HEADER;
  endfunction

endpackage

// File: rtl/switch_output_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set bit of req at or after ptr, wrapping N-1 -> 0.
// Ports: req (request vector), ptr (search start) -> found (any request), winner (index).
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
module rr_priority_picker #(
  parameter int N    = 4,
  parameter int LOGN = 2
) (
  input  logic [N-1:0]    req,
  input  logic [LOGN-1:0] ptr,
  output logic            found,
  output logic [LOGN-1:0] winner
);

  logic [LOGN:0]   sum;
  logic [LOGN-1:0] idx;

  // Walk offsets 0..N-1 from ptr; the first hit is kept, later hits are ignored.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (LOGN+1)'(k);
      // Modulo N without a divider; ptr < N and k < N so one subtraction suffices.
      if (sum >= (LOGN+1)'(N)) begin
        sum = sum - (LOGN+1)'(N);
      end
      idx = sum[LOGN-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/switch_output_arbiter.sv
// Output-port arbiter: locks the output to one input for a whole packet, round-robin between packets.
// Ports: req_hdr/req_valid/req_tail per input, out_stall in; grant/grant_idx/locked registered, fire/in_stall comb.
// Latency: one cycle header-to-grant; bubble after tail. Backpressure: out_stall blocks fire and stalls all inputs.
module switch_output_arbiter
  import switch_output_arbiter_pkg::*;
#(
  parameter int NUMBERINPUTS    = 4,
  parameter int LOGNUMBERINPUTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUMBERINPUTS-1:0]    req_hdr,
  input  logic [NUMBERINPUTS-1:0]    req_valid,
  input  logic [NUMBERINPUTS-1:0]    req_tail,
  input  logic                       out_stall,
  output logic [NUMBERINPUTS-1:0]    grant,
  output logic [LOGNUMBERINPUTS-1:0] grant_idx,
  output logic                       locked,
  output logic                       fire,
  output logic [NUMBERINPUTS-1:0]    in_stall
);

  arb_state_t                 state_q;
  logic [LOGNUMBERINPUTS-1:0] ptr_q;
  logic [NUMBERINPUTS-1:0]    grant_q;
  logic [LOGNUMBERINPUTS-1:0] grant_idx_q;
  logic                       locked_q;

  logic                       pick_found;
  logic [LOGNUMBERINPUTS-1:0] pick_winner;
  logic [LOGNUMBERINPUTS-1:0] ptr_d;
  logic [NUMBERINPUTS-1:0]    winner_onehot;

  rr_priority_picker #(
    .N    (NUMBERINPUTS),
    .LOGN (LOGNUMBERINPUTS)
  ) u_picker (
    .req    (req_hdr),
    .ptr    (ptr_q),
    .found  (pick_found),
    .winner (pick_winner)
  );

  // Pointer moves just past the winner so the winner has lowest priority next time.
  assign ptr_d = (pick_winner == LOGNUMBERINPUTS'(NUMBERINPUTS-1)) ? '0 : pick_winner + 1'b1;
  assign winner_onehot = {{(NUMBERINPUTS-1){1'b0}}, 1'b1} << pick_winner;

  // rst is gated in so a packet being abandoned by reset cannot transfer a flit.
  assign fire = locked_q & req_valid[grant_idx_q] & ~out_stall & ~rst;

  always_comb begin
    in_stall = '1;
    if (locked_q && !out_stall && !rst) begin
      in_stall = ~grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q     <= LOCKED;
            grant_q     <= winner_onehot;
            grant_idx_q <= pick_winner;
            ptr_q       <= ptr_d;
            locked_q    <= 1'b1;
          end
        end
        LOCKED: begin
          // Only the owner's tail releases the output; grant_idx keeps the last mux select.
          if (fire && req_tail[grant_idx_q]) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_switch_output_arbiter.sv
module tb_switch_output_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_hdr;
  logic [3:0] req_valid;
  logic [3:0] req_tail;
  logic       out_stall;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       locked;
  logic       fire;
  logic [3:0] in_stall;

  int checks = 0;
  int errors = 0;

  // Reference model: which input owns the output (-1 = nobody) and where the next search starts.
  int m_owner = -1;
  int m_ptr   = 0;

  always #5 clk = ~clk;

  switch_output_arbiter #(
    .NUMBERINPUTS    (4),
    .LOGNUMBERINPUTS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_hdr   (req_hdr),
    .req_valid (req_valid),
    .req_tail  (req_tail),
    .out_stall (out_stall),
    .grant     (grant),
    .grant_idx (grant_idx),
    .locked    (locked),
    .fire      (fire),
    .in_stall  (in_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int o);
    logic [3:0] one;
    one = 4'b0001;
    return (o < 0) ? 4'b0000 : (one << o);
  endfunction

  // One clock cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic cyc(input logic r, input logic [3:0] h, input logic [3:0] v,
                     input logic [3:0] t, input logic s);
    logic       m_fire;
    logic [3:0] m_stall;
    int         w;
    rst       = r;
    req_hdr   = h;
    req_valid = v;
    req_tail  = t;
    out_stall = s;
    #1;
    m_fire  = !r && (m_owner >= 0) && v[m_owner] && !s;
    m_stall = (!r && (m_owner >= 0) && !s) ? ~onehot(m_owner) : 4'b1111;
    check("grant", grant, onehot(m_owner));
    check("locked", locked, m_owner >= 0);
    if (m_owner >= 0) check("grant_idx", grant_idx, m_owner);
    check("fire", fire, m_fire);
    check("in_stall", in_stall, m_stall);
    @(posedge clk);
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && h[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
      end
    end else if (m_fire && t[m_owner]) begin
      m_owner = -1;
    end
    #1;
  endtask

  initial begin
    logic [3:0] rh, rv, rt;
    logic       rr, rs;
    rst = 1'b1; req_hdr = '0; req_valid = '0; req_tail = '0; out_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset state
    cyc(1, 4'b0000, 4'b0000, 4'b0000, 0);
    check("rst_grant", grant, 4'b0000);
    check("rst_locked", locked, 1'b0);

    // First arbitration from ptr=0: 0110 -> input 1
    cyc(0, 4'b0110, 4'b0000, 4'b0000, 0);
    check("arb1_grant", grant, 4'b0010);
    check("arb1_idx", grant_idx, 2'd1);

    // Owner 1: header, two payloads, tail; input 2 keeps its header up
    cyc(0, 4'b0110, 4'b0010, 4'b0000, 0);
    cyc(0, 4'b0100, 4'b0010, 4'b0000, 0);
    cyc(0, 4'b0100, 4'b0010, 4'b0000, 0);
    cyc(0, 4'b0100, 4'b0010, 4'b0010, 0);
    check("tail_unlock", locked, 1'b0);
    cyc(0, 4'b0100, 4'b0000, 4'b0000, 0);
    check("next_grant2", grant, 4'b0100);

    // Release input 2 (ptr now 3), then 1001 -> input 3, wrap, then 1001 -> input 0
    cyc(0, 4'b0000, 4'b0100, 4'b0100, 0);
    cyc(0, 4'b1001, 4'b0000, 4'b0000, 0);
    check("wrap_grant3", grant, 4'b1000);
    cyc(0, 4'b1001, 4'b1000, 4'b1000, 0);
    cyc(0, 4'b1001, 4'b0000, 4'b0000, 0);
    check("wrap_grant0", grant, 4'b0001);

    // Owner 0 tail held under out_stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b0000, 4'b0001, 4'b0001, 1);
      check("stall_locked", locked, 1'b1);
    end
    cyc(0, 4'b0000, 4'b0001, 4'b0001, 0);
    check("stall_release", locked, 1'b0);

    // Reset mid-packet with ptr=2, then all headers -> input 0
    cyc(0, 4'b0010, 4'b0000, 4'b0000, 0);
    cyc(0, 4'b0010, 4'b0010, 4'b0000, 0);
    cyc(1, 4'b0010, 4'b0010, 4'b0000, 0);
    check("midrst_grant", grant, 4'b0000);
    check("midrst_locked", locked, 1'b0);
    cyc(0, 4'b1111, 4'b0000, 4'b0000, 0);
    check("postrst_grant", grant, 4'b0001);

    // All inputs keep headers up: ownership rotates 0 -> 1 -> 2 -> 3 -> 0 -> 1
    for (int p = 0; p < 5; p++) begin
      cyc(0, 4'b1111, onehot(p % 4), onehot(p % 4), 0);
      cyc(0, 4'b1111, 4'b0000, 4'b0000, 0);
      check("rotate_grant", grant, onehot((p + 1) % 4));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 59) == 0);
      rh = 4'($urandom);
      rv = 4'($urandom);
      rt = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      rs = ($urandom_range(0, 3) == 0);
      cyc(rr, rh, rv, rt, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
